vedic_mul_pipe: RTL and testbench

VEDIC_MUL_PIPE -- requirements
Module: vedic_mul_pipe

---
 rtl/vedic_pkg.sv | 18 +
 rtl/vedic_mul_nxn.sv | 46 ++++
 rtl/vedic_mul_pipe.sv | 149 ++++++++++++++
 tb/tb_vedic_mul_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared constants for the Vedic pipelined multiplier.
// Holds pipeline latency, legal operand widths and the width check.
package vedic_pkg;

  localparam int LATENCY = 3;
  localparam int N_LEGAL = 4;
  localparam int LEGAL_WIDTHS [N_LEGAL] = '{4, 8, 16, 32};

  function automatic bit width_ok(input int w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < N_LEGAL; i++) begin
      if (LEGAL_WIDTHS[i] == w) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/vedic_mul_nxn.sv
// Combinational NxN Vedic multiplier, N a power of two >= 2.
// Recurses on halves down to 2x2 cells built from half-adders.
module vedic_mul_nxn
  import vedic_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] p
);

  if (N == 2) begin : g_cell
    logic t1, t2, t3, c1;
    assign t1   = x[1] & y[0];
    assign t2   = x[0] & y[1];
    assign t3   = x[1] & y[1];
    assign p[0] = x[0] & y[0];
    assign p[1] = t1 ^ t2;
    assign c1   = t1 & t2;
    assign p[2] = t3 ^ c1;
    assign p[3] = t3 & c1;
  end else begin : g_rec
    localparam int H = N / 2;
    logic [N-1:0] hh, hl, lh, ll;
    logic [N:0]   mid;

    vedic_mul_nxn #(.N(H)) u_hh (
      .x(x[N-1:H]), .y(y[N-1:H]), .p(hh)
    );
    vedic_mul_nxn #(.N(H)) u_hl (
      .x(x[N-1:H]), .y(y[H-1:0]), .p(hl)
    );
    vedic_mul_nxn #(.N(H)) u_lh (
      .x(x[H-1:0]), .y(y[N-1:H]), .p(lh)
    );
    vedic_mul_nxn #(.N(H)) u_ll (
      .x(x[H-1:0]), .y(y[H-1:0]), .p(ll)
    );

    assign mid = {1'b0, hl} + {1'b0, lh};
    assign p   = {hh, ll}
               + {{(H-1){1'b0}}, mid, {H{1'b0}}};
  end

endmodule

// File: rtl/vedic_mul_pipe.sv
// Three-stage pipelined Vedic multiplier with valid/ready handshake.
// Define VEDIC_MUL_SIGNED_EN for two's complement operands and product.
module vedic_mul_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out
);

  localparam int H      = WIDTH / 2;
  localparam int W2     = 2 * WIDTH;
  localparam int STAGES = 3;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("vedic_mul_pipe: illegal WIDTH %0d", WIDTH);
  end
  if (STAGES != LATENCY) begin : g_bad_lat
    $error("vedic_mul_pipe: stage count mismatch");
  end

  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
  logic [WIDTH-1:0] hh_q, hh_d, hl_q, hl_d;
  logic [WIDTH-1:0] lh_q, lh_d, ll_q, ll_d;
  logic [W2-1:0]    out_q, out_d;
  logic [WIDTH-1:0] pp_hh, pp_hl, pp_lh, pp_ll;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mid;
  logic [W2-1:0]    mag, prod;
  logic             adv;

`ifdef VEDIC_MUL_SIGNED_EN
  logic sg1_q, sg1_d, sg2_q, sg2_d;
  assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign prod  = sg2_q ? (~mag + 1'b1) : mag;
`else
  assign a_mag = a;
  assign b_mag = b;
  assign prod  = mag;
`endif

  assign in_ready  = !v3_q || out_ready;
  assign adv       = in_ready;
  assign out_valid = v3_q;
  assign out       = out_q;

  vedic_mul_nxn #(.N(H)) u_pp_hh (
    .x(a1_q[WIDTH-1:H]), .y(b1_q[WIDTH-1:H]), .p(pp_hh)
  );
  vedic_mul_nxn #(.N(H)) u_pp_hl (
    .x(a1_q[WIDTH-1:H]), .y(b1_q[H-1:0]), .p(pp_hl)
  );
  vedic_mul_nxn #(.N(H)) u_pp_lh (
    .x(a1_q[H-1:0]), .y(b1_q[WIDTH-1:H]), .p(pp_lh)
  );
  vedic_mul_nxn #(.N(H)) u_pp_ll (
    .x(a1_q[H-1:0]), .y(b1_q[H-1:0]), .p(pp_ll)
  );

  assign mid = {1'b0, hl_q} + {1'b0, lh_q};
  assign mag = {hh_q, ll_q}
             + {{(H-1){1'b0}}, mid, {H{1'b0}}};

  // Whole pipeline moves together; data only loads behind a valid bit.
  always_comb begin
    v1_d  = v1_q;
    a1_d  = a1_q;
    b1_d  = b1_q;
    v2_d  = v2_q;
    hh_d  = hh_q;
    hl_d  = hl_q;
    lh_d  = lh_q;
    ll_d  = ll_q;
    v3_d  = v3_q;
    out_d = out_q;
`ifdef VEDIC_MUL_SIGNED_EN
    sg1_d = sg1_q;
    sg2_d = sg2_q;
`endif
    if (adv) begin
      v1_d = in_valid;
      if (in_valid) begin
        a1_d = a_mag;
        b1_d = b_mag;
`ifdef VEDIC_MUL_SIGNED_EN
        sg1_d = a[WIDTH-1] ^ b[WIDTH-1];
`endif
      end
      v2_d = v1_q;
      if (v1_q) begin
        hh_d = pp_hh;
        hl_d = pp_hl;
        lh_d = pp_lh;
        ll_d = pp_ll;
`ifdef VEDIC_MUL_SIGNED_EN
        sg2_d = sg1_q;
`endif
      end
      v3_d = v2_q;
      if (v2_q) out_d = prod;
    end
  end

  // Stage registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      a1_q  <= '0;
      b1_q  <= '0;
      v2_q  <= 1'b0;
      hh_q  <= '0;
      hl_q  <= '0;
      lh_q  <= '0;
      ll_q  <= '0;
      v3_q  <= 1'b0;
      out_q <= '0;
`ifdef VEDIC_MUL_SIGNED_EN
      sg1_q <= 1'b0;
      sg2_q <= 1'b0;
`endif
    end else begin
      v1_q  <= v1_d;
      a1_q  <= a1_d;
      b1_q  <= b1_d;
      v2_q  <= v2_d;
      hh_q  <= hh_d;
      hl_q  <= hl_d;
      lh_q  <= lh_d;
      ll_q  <= ll_d;
      v3_q  <= v3_d;
      out_q <= out_d;
`ifdef VEDIC_MUL_SIGNED_EN
      sg1_q <= sg1_d;
      sg2_q <= sg2_d;
`endif
    end
  end

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Self-checking bench for vedic_mul_pipe (WIDTH=8 and WIDTH=4).
// Queue-based product model, directed corners plus random traffic.
module tb_vedic_mul_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        iv = 1'b0, irdy, ov, ordy = 1'b1;
  logic [7:0]  ia = '0, ib = '0;
  logic [15:0] o;

  logic        iv4 = 1'b0, irdy4, ov4, ordy4 = 1'b1;
  logic [3:0]  ia4 = '0, ib4 = '0;
  logic [7:0]  o4;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int dlv_cnt = 0;
  int dlv4 = 0;
  int first4 = 0;
  int last4 = 0;

  longint unsigned exp_q[$];
  longint unsigned exp4_q[$];

  logic [15:0] last_out = '0;
  logic [15:0] stall_out = '0;
  logic        stall_p = 1'b0;
  logic        was_rst = 1'b0;

  vedic_mul_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv), .in_ready(irdy),
    .a(ia), .b(ib),
    .out_valid(ov), .out_ready(ordy),
    .out(o)
  );

  vedic_mul_pipe #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(iv4), .in_ready(irdy4),
    .a(ia4), .b(ib4),
    .out_valid(ov4), .out_ready(ordy4),
    .out(o4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint unsigned mdl(
    input longint unsigned x,
    input longint unsigned y,
    input int w
  );
    longint sx, sy, p;
    longint unsigned m;
    m  = (64'd1 << (2 * w)) - 64'd1;
    sx = longint'(x);
    sy = longint'(y);
`ifdef VEDIC_MUL_SIGNED_EN
    if (x[w-1]) sx = sx - (longint'(1) << w);
    if (y[w-1]) sy = sy - (longint'(1) << w);
`endif
    p = sx * sy;
    return longint'(p) & m;
  endfunction

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] req
  );
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)",
               nm, act, req, $time);
    end
  endtask

  // WIDTH=8 scoreboard: handshake, ordering, stall and hold rules.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_out = '0;
      stall_p  = 1'b0;
      was_rst  = 1'b1;
    end else begin
      if (was_rst) begin
        chk("rst_out_valid", {63'd0, ov}, 64'd0);
        chk("rst_out", {48'd0, o}, 64'd0);
        chk("rst_in_ready", {63'd0, irdy}, 64'd1);
        was_rst = 1'b0;
      end
      chk("in_ready_rule", {63'd0, irdy},
          {63'd0, (!ov || ordy)});
      if (stall_p) begin
        chk("stall_valid", {63'd0, ov}, 64'd1);
        chk("stall_out", {48'd0, o}, {48'd0, stall_out});
      end
      if (!ov)
        chk("hold_out", {48'd0, o}, {48'd0, last_out});
      if (ov && ordy) begin
        if (exp_q.size() == 0)
          chk("spurious_out", 64'd1, 64'd0);
        else
          chk("product", {48'd0, o}, exp_q.pop_front());
        last_out = o;
        dlv_cnt++;
      end
      if (iv && irdy) begin
        exp_q.push_back(mdl(ia, ib, 8));
        acc_cnt++;
      end
      stall_p   = ov && !ordy;
      stall_out = o;
    end
  end

  // WIDTH=4 scoreboard: in-order products and delivery cycle span.
  always @(negedge clk) begin
    if (rst) begin
      exp4_q.delete();
    end else begin
      if (ov4 && ordy4) begin
        if (exp4_q.size() == 0)
          chk("w4_spurious", 64'd1, 64'd0);
        else
          chk("w4_product", {56'd0, o4}, exp4_q.pop_front());
        dlv4++;
        if (dlv4 == 1) first4 = cyc;
        last4 = cyc;
      end
      if (iv4 && irdy4)
        exp4_q.push_back(mdl(ia4, ib4, 4));
    end
  end

  logic [7:0] bpa [4] = '{8'd3, 8'd200, 8'd17, 8'd255};
  logic [7:0] bpb [4] = '{8'd9, 8'd150, 8'd254, 8'd255};

  initial begin
    int acc0, d0, idx, budget;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 255*255 accepted in cycle 0, product visible in cycle 3.
    ordy = 1'b1;
    iv = 1'b1; ia = 8'd255; ib = 8'd255;
    @(posedge clk); #1 iv = 1'b0;
    @(negedge clk);
    chk("lat_c1_valid", {63'd0, ov}, 64'd0);
    @(negedge clk);
    chk("lat_c2_valid", {63'd0, ov}, 64'd0);
    @(negedge clk);
    chk("lat_c3_valid", {63'd0, ov}, 64'd1);
`ifdef VEDIC_MUL_SIGNED_EN
    chk("lat_c3_out", {48'd0, o}, 64'd1);
`else
    chk("lat_c3_out", {48'd0, o}, 64'd65025);
`endif
    repeat (3) @(posedge clk);
    #1;

`ifdef VEDIC_MUL_SIGNED_EN
    iv = 1'b1; ia = 8'h80; ib = 8'h80;
    @(posedge clk); #1 ia = 8'hFF; ib = 8'h7F;
    @(posedge clk); #1 ia = 8'h00; ib = 8'hFB;
    @(posedge clk); #1 iv = 1'b0;
    @(negedge clk);
    chk("sgn_m128sq", {48'd0, o}, 64'd16384);
    @(negedge clk);
    chk("sgn_m1x127", {48'd0, o}, 64'h0000_0000_0000_FF81);
    @(negedge clk);
    chk("sgn_0xm5", {48'd0, o}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
`endif

    // WIDTH=4: every pair, back-to-back.
    for (int i = 0; i < 256; i++) begin
      iv4 = 1'b1;
      ia4 = 4'(i >> 4);
      ib4 = 4'(i);
      @(posedge clk); #1;
    end
    iv4 = 1'b0;
    budget = 0;
    while (dlv4 < 256 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("w4_count", 64'(dlv4), 64'd256);
    chk("w4_span", 64'(last4 - first4), 64'd255);

    // Backpressure: out_ready low, four pairs offered.
    repeat (2) @(posedge clk);
    #1;
    ordy = 1'b0;
    acc0 = acc_cnt;
    for (int c = 0; c < 5; c++) begin
      idx = acc_cnt - acc0;
      iv = (idx < 4);
      if (idx < 4) begin
        ia = bpa[idx];
        ib = bpb[idx];
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bp_in_ready", {63'd0, irdy}, 64'd0);
    chk("bp_held", 64'(acc_cnt - acc0), 64'd3);
    @(posedge clk); #1;
    ordy = 1'b1;
    budget = 0;
    while (!((acc_cnt - acc0) == 4 && exp_q.size() == 0)
           && budget < 20) begin
      idx = acc_cnt - acc0;
      iv = (idx < 4);
      if (idx < 4) begin
        ia = bpa[idx];
        ib = bpb[idx];
      end
      @(posedge clk); #1;
      budget++;
    end
    iv = 1'b0;
    chk("bp_all_acc", 64'(acc_cnt - acc0), 64'd4);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset with three operations in flight.
    repeat (2) @(posedge clk);
    #1;
    iv = 1'b1; ia = 8'd12; ib = 8'd34;
    @(posedge clk); #1 ia = 8'd56; ib = 8'd78;
    @(posedge clk); #1 ia = 8'd90; ib = 8'd11;
    @(posedge clk); #1 iv = 1'b0;
    chk("rs_full_valid", {63'd0, ov}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    d0 = dlv_cnt;
    repeat (8) @(posedge clk);
    #1;
    chk("rs_no_stale", 64'(dlv_cnt - d0), 64'd0);

    // Random traffic with occasional reset.
    for (int c = 0; c < 2000; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0: ia = 8'h00;
        1: ia = 8'hFF;
        2: ia = 8'h80;
        default: ia = 8'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: ib = 8'h00;
        1: ib = 8'hFF;
        2: ib = 8'h7F;
        default: ib = 8'($urandom);
      endcase
      rst = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    rst  = 1'b0;
    iv   = 1'b0;
    ordy = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("final_drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
